// File: rtl/barrel_pkg.sv
// Shared types and helpers for the barrel-shift command issue stage.
// The helper decodes a binary shift amount into the barrel stage's one-hot select.
package barrel_pkg;

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] amt;
  } shift_cmd_t;

  localparam logic [7:0] DONE_MAX = 8'd255;

  // Amounts of 4 or more give an all-zero select, so the barrel stage returns zero.
  function automatic logic [3:0] amt_to_onehot(input logic [2:0] amt);
    logic [3:0] n;
    n = 4'b0000;
    if (!amt[2]) n[amt[1:0]] = 1'b1;
    return n;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO of shift commands.
// The head is read combinationally so it can drive the barrel stage directly.
module cmd_fifo
  import barrel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  shift_cmd_t push_cmd,
  input  logic       pop,
  output shift_cmd_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  shift_cmd_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wr_ptr] <= push_cmd;
  end

endmodule

// File: rtl/barrel_shift_issue.sv
// Command issue stage for the 4-bit one-hot barrel-vector stage: buffers commands,
// drives the barrel stage from the FIFO head and registers its result.
module barrel_shift_issue
  import barrel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic [2:0] in_amt,
  output logic [3:0] bv_d,
  output logic [3:0] bv_n,
  input  logic [3:0] bv_w,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_zero,
  output logic [7:0] done_cnt
);

  shift_cmd_t push_cmd;
  shift_cmd_t head;
  logic       full;
  logic       empty;
  logic       issue;
  logic       deliver;

  assign push_cmd = '{data: in_data, amt: in_amt};
  assign in_ready = !full;
  assign issue    = !empty && (!out_valid || out_ready);
  assign deliver  = out_valid && out_ready;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_valid),
    .push_cmd (push_cmd),
    .pop      (issue),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // Idle barrel inputs are held at zero so stale FIFO contents never leak out.
  assign bv_d = empty ? 4'b0000 : head.data;
  assign bv_n = empty ? 4'b0000 : amt_to_onehot(head.amt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 4'b0000;
      out_zero  <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_data  <= bv_w;
      out_zero  <= (bv_w == 4'b0000);
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_cnt <= 8'd0;
    end else if (deliver && (done_cnt != DONE_MAX)) begin
      done_cnt <= done_cnt + 8'd1;
    end
  end

endmodule
